// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the 8-register bus datapath: decodes mvi/mv/add/sub
// into a short Moore sequence of registered bus, register-load and ALU enables.
module datapath_ctrl #(
    parameter int ADDR_W = 3,
    parameter int OP_W   = 2,
    localparam int NUM_REGS = 2**ADDR_W,
    localparam int INSTR_W  = OP_W + 2*ADDR_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                run,
    input  logic [INSTR_W-1:0]  instr,
    output logic                ready,
    output logic                done,
    output logic                ext_data_en,
    output logic [NUM_REGS-1:0] reg_in_en,
    output logic [NUM_REGS-1:0] reg_out_en,
    output logic                alu_reg_en,
    output logic                alu_sel,
    output logic                alu_out_en,
    output logic                g_reg_en
);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    localparam logic [OP_W-1:0] OP_MVI = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MV  = OP_W'(1);

    state_t               state_reg, state_next;
    logic [INSTR_W-1:0]   ir_reg, ir_next;
    logic [OP_W-1:0]      op_next;
    logic [ADDR_W-1:0]    rx_next, ry_next;
    logic [NUM_REGS-1:0]  rx_hot_next, ry_hot_next;

    logic                 ready_next, done_next, ext_data_en_next;
    logic                 alu_reg_en_next, alu_sel_next, alu_out_en_next, g_reg_en_next;
    logic [NUM_REGS-1:0]  reg_in_en_next, reg_out_en_next;

    assign op_next = ir_next[INSTR_W-1 -: OP_W];
    assign rx_next = ir_next[2*ADDR_W-1 -: ADDR_W];
    assign ry_next = ir_next[ADDR_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
            assign rx_hot_next[gi] = (rx_next == ADDR_W'(gi));
            assign ry_hot_next[gi] = (ry_next == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        case (state_reg)
            IDLE: if (run) begin
                state_next = T1;
                ir_next    = instr;
            end
            T1:      state_next = (ir_reg[INSTR_W-1 -: OP_W] == OP_MVI ||
                                   ir_reg[INSTR_W-1 -: OP_W] == OP_MV) ? IDLE : T2;
            T2:      state_next = T3;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and IR so they can be registered
    // while still appearing in the same cycle as that state.
    always_comb begin
        ready_next       = (state_next == IDLE);
        done_next        = 1'b0;
        ext_data_en_next = 1'b0;
        reg_in_en_next   = '0;
        reg_out_en_next  = '0;
        alu_reg_en_next  = 1'b0;
        alu_sel_next     = 1'b0;
        alu_out_en_next  = 1'b0;
        g_reg_en_next    = 1'b0;
        case (state_next)
            T1: begin
                if (op_next == OP_MVI) begin
                    ext_data_en_next = 1'b1;
                    reg_in_en_next   = rx_hot_next;
                    done_next        = 1'b1;
                end else if (op_next == OP_MV) begin
                    reg_out_en_next  = ry_hot_next;
                    reg_in_en_next   = rx_hot_next;
                    done_next        = 1'b1;
                end else begin
                    reg_out_en_next  = rx_hot_next;
                    alu_reg_en_next  = 1'b1;
                end
            end
            T2: begin
                reg_out_en_next = ry_hot_next;
                g_reg_en_next   = 1'b1;
                alu_sel_next    = op_next[0];
            end
            T3: begin
                alu_out_en_next = 1'b1;
                reg_in_en_next  = rx_hot_next;
                done_next       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            ir_reg      <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            ext_data_en <= 1'b0;
            reg_in_en   <= '0;
            reg_out_en  <= '0;
            alu_reg_en  <= 1'b0;
            alu_sel     <= 1'b0;
            alu_out_en  <= 1'b0;
            g_reg_en    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ir_reg      <= ir_next;
            ready       <= ready_next;
            done        <= done_next;
            ext_data_en <= ext_data_en_next;
            reg_in_en   <= reg_in_en_next;
            reg_out_en  <= reg_out_en_next;
            alu_reg_en  <= alu_reg_en_next;
            alu_sel     <= alu_sel_next;
            alu_out_en  <= alu_out_en_next;
            g_reg_en    <= g_reg_en_next;
        end
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Instruction sequencer that drives the control inputs of the existing 8-register bus datapath.
- It takes an 8-bit instruction and a run strobe, and produces the one-hot register enables, the external-data, ALU and G-register enables, and a done pulse.
- It replaces hand-scripted control vectors so the datapath can run mvi, mv, add and sub sequences autonomously.

Parameters:
- ADDR_W, 3, register-select field width. NUM_REGS = 2**ADDR_W is the width of the one-hot enables.
- OP_W, 2, opcode field width. Instruction width = OP_W + 2*ADDR_W (8 at defaults).

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- run  in  1  start strobe, sampled only in IDLE
- instr  in  OP_W+2*ADDR_W  instruction: [7:6] op, [5:3] rx (destination), [2:0] ry (source)
- ready  out  1  high in IDLE (instruction will be accepted)
- done  out  1  one-cycle pulse in the final state of each instruction
- ext_data_en  out  1  drive external data onto the bus
- reg_in_en  out  NUM_REGS  one-hot load enable for R0..R7
- reg_out_en  out  NUM_REGS  one-hot bus-drive enable for R0..R7
- alu_reg_en  out  1  load the ALU A register from the bus
- alu_sel  out  1  0 = A+bus, 1 = A-bus
- alu_out_en  out  1  drive the G register onto the bus
- g_reg_en  out  1  load the G register from the ALU

Behaviour:
- Opcodes:
  - 00 mvi: Rx <- ext_data
  - 01 mv: Rx <- Ry
  - 10 add: Rx <- Rx + Ry
  - 11 sub: Rx <- Rx - Ry
- State register: IDLE, T1, T2, T3. Instruction register IR has the full instruction width.
- Reset (async, resetn=0):
  - state=IDLE, IR=0.
  - All control outputs 0, done=0, ready=1.
  - This takes effect immediately, including mid-instruction. The aborted instruction leaves no further enables.
- IDLE:
  - ready=1, all enables 0.
  - If run=1 at a rising edge: IR<=instr and state<=T1. Otherwise stay in IDLE.
- Non-IDLE states: ready=0. run and instr are ignored; IR holds.
- Outputs are Moore, decoded from state and IR only, never from live instr. onehot(x) means a 1 in bit x only.
- mvi:
  - T1: ext_data_en=1, reg_in_en=onehot(rx), done=1.
  - Next state: IDLE.
- mv:
  - T1: reg_out_en=onehot(ry), reg_in_en=onehot(rx), done=1.
  - Next state: IDLE.
  - rx==ry is legal (self-load, no hazard).
- add/sub:
  - T1: reg_out_en=onehot(rx), alu_reg_en=1.
  - T2: reg_out_en=onehot(ry), g_reg_en=1, alu_sel=IR[6].
  - T3: alu_out_en=1, reg_in_en=onehot(rx), done=1.
  - Next state: IDLE.
  - alu_sel=0 in all other states.
  - rx==ry is legal (Rx+Rx or Rx-Rx=0).
- Latency, counted from the edge that samples run=1:
  - mvi/mv: done is high during the next cycle. Issue-to-issue is 2 cycles minimum.
  - add/sub: done is high during the 3rd cycle. Issue-to-issue is 4 cycles minimum.
- Bus exclusivity invariant, every cycle: at most one bus driver is active (ext_data_en, any reg_out_en bit, alu_out_en), and reg_out_en is zero or one-hot.
- reg_in_en is zero or one-hot. No more than one of alu_reg_en and g_reg_en is high in any cycle.
- run held high continuously: one instruction is accepted per visit to IDLE, and each acceptance re-samples instr.
- X/undefined opcodes are impossible (2-bit field fully decoded).

Test Plan:
- Reset mid-add: issue instr=8'b10_001_010, assert resetn=0 during T2 -> all outputs 0 immediately, ready=1; after release the bench stays idle with no enables until the next run.
- mvi: run=1, instr=8'b00_011_000 -> next cycle ext_data_en=1, reg_in_en=8'b00001000, done=1; following cycle ready=1, all enables 0. On the datapath, R3 = ext_data (16'h0001).
- mv: preload R3=16'h0005, issue instr=8'b01_000_011 -> one cycle with reg_out_en=8'b00001000, reg_in_en=8'b00000001, done=1. R0 = 16'h0005.
- add then sub: R0=5, R1=3. Issue 8'b10_000_001 -> T1 reg_out_en=01h, alu_reg_en; T2 reg_out_en=02h, g_reg_en, alu_sel=0; T3 alu_out_en, reg_in_en=01h, done. R0=8. Then 8'b11_000_001 -> R0=5, alu_sel=1 only in T2.
- Back-to-back with run held high through 4 mixed instructions, with instr changed mid-instruction -> IR unaffected, exactly 4 done pulses, bus-exclusivity assertion never fires.
- rx==ry sub: R2=16'h0007, instr=8'b11_010_010 -> R2=16'h0000 after done.
